sync_fifo_thresh: RTL and testbench

- Single-clock, parametrised FIFO. It succeeds the dual-clock FIFO for intra-domain buffering.
- Adds an occupancy count, programmable almost-full and almost-empty flags, and single-cycle overflow/underflow error pulses.
- Sits between producer and consumer logic in the same clock domain.
- Storage is an inferred register array of DEPTH x WIDTH.

---
 rtl/sync_fifo_thresh.sv | 127 ++++++++++++
 tb/tb_sync_fifo_thresh.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_thresh.sv
// sync_fifo_thresh: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags and one-cycle overflow/underflow pulses.
// Optional first-word fall-through read port: define SYNC_FIFO_FWFT_EN.
module sync_fifo_thresh #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned PTR_WIDTH = $clog2(DEPTH),
  parameter int unsigned AF_THRESH = DEPTH - 4,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);

  localparam int unsigned CNT_W  = PTR_WIDTH + 1;
  localparam logic        AF_RST = (AF_THRESH == 0);

  logic [WIDTH-1:0]     mem [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 af_q, af_d;
  logic                 ae_q, ae_d;
  logic                 wr_err_q, wr_err_d;
  logic                 rd_err_q, rd_err_d;
  logic                 wr_accept_c;
  logic                 rd_accept_c;
  logic [WIDTH-1:0]     head_c;

  assign head_c = mem[rd_ptr_q];

  // Accept decisions, pointer/count next state and flags from the next count.
  always_comb begin
    wr_accept_c = wr_en_i & ~full_q;
    rd_accept_c = rd_en_i & ~empty_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_accept_c) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (rd_accept_c) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({wr_accept_c, rd_accept_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == CNT_W'(0));
    af_d     = (count_d >= CNT_W'(AF_THRESH));
    ae_d     = (count_d <= CNT_W'(AE_THRESH));
    wr_err_d = wr_en_i & full_q;
    rd_err_d = rd_en_i & empty_q;
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= AF_RST;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_accept_c) mem[wr_ptr_q] <= wdata_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; zero while empty.
  assign rdata_o = empty_q ? '0 : head_c;
`else
  logic [WIDTH-1:0] rdata_q, rdata_d;

  // Registered read data holds its value unless a read is accepted.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_accept_c) rdata_d = head_c;
  end

  // Read data register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
`endif

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign count_o        = count_q;
  assign wr_error_o     = wr_err_q;
  assign rd_error_o     = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench for sync_fifo_thresh with a queue model and a
// scoreboard of expected read data. Honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_thresh;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned PW    = 9;
  localparam int unsigned AF    = DEPTH - 4;
  localparam int unsigned AE    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rdata;
  logic             full, empty, afull, aempty, wr_err, rd_err;
  logic [PW:0]      count;

  int n_chk = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mq[$];      // model FIFO contents
  logic [WIDTH-1:0] exp_q[$];   // scoreboard of expected rdata
  logic [WIDTH-1:0] last_rd = '0;
  bit               exp_werr, exp_rerr;

  sync_fifo_thresh #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_WIDTH(PW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
    .rdata_o(rdata), .full_o(full), .empty_o(empty), .almost_full_o(afull),
    .almost_empty_o(aempty), .count_o(count), .wr_error_o(wr_err), .rd_error_o(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all status outputs against the model.
  task automatic chk_status(input string tag);
    int c;
    c = mq.size();
    chk({tag, ".count"},  32'(count),  32'(c));
    chk({tag, ".empty"},  32'(empty),  32'(c == 0));
    chk({tag, ".full"},   32'(full),   32'(c == DEPTH));
    chk({tag, ".afull"},  32'(afull),  32'(c >= AF));
    chk({tag, ".aempty"}, 32'(aempty), 32'(c <= AE));
    chk({tag, ".wr_err"}, 32'(wr_err), 32'(exp_werr));
    chk({tag, ".rd_err"}, 32'(rd_err), 32'(exp_rerr));
  endtask

  // One clock of stimulus; model updated at drive time, DUT checked after the edge.
  task automatic step(input bit wr, input logic [WIDTH-1:0] wd, input bit rd, input string tag);
    bit wa, ra;
    @(negedge clk);
    wr_en = wr; wdata = wd; rd_en = rd;
    wa = wr && (mq.size() < DEPTH);
    ra = rd && (mq.size() > 0);
    exp_werr = wr && (mq.size() == DEPTH);
    exp_rerr = rd && (mq.size() == 0);
    if (ra) last_rd = mq.pop_front();
    if (wa) mq.push_back(wd);
`ifdef SYNC_FIFO_FWFT_EN
    exp_q.push_back(mq.size() > 0 ? mq[0] : '0);
`else
    exp_q.push_back(last_rd);
`endif
    @(posedge clk);
    #1;
    chk_status(tag);
    chk({tag, ".rdata"}, 32'(rdata), 32'(exp_q.pop_front()));
  endtask

  task automatic idle();
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    exp_werr = 1'b0; exp_rerr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".count"},  32'(count),  32'd0);
    chk({tag, ".empty"},  32'(empty),  32'd1);
    chk({tag, ".full"},   32'(full),   32'd0);
    chk({tag, ".aempty"}, 32'(aempty), 32'd1);
    chk({tag, ".afull"},  32'(afull),  32'd0);
    chk({tag, ".wr_err"}, 32'(wr_err), 32'd0);
    chk({tag, ".rd_err"}, 32'(rd_err), 32'd0);
    chk({tag, ".rdata"},  32'(rdata),  32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    last_rd = '0;
    exp_werr = 1'b0;
    exp_rerr = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;

    // 1: four writes, count steps 1..4, almost_empty drops at 5
    for (int i = 0; i < 4; i++) begin
      step(1'b1, WIDTH'(8'h11 + i), 1'b0, "t1.wr");
      chk("t1.aempty_hold", 32'(aempty), 32'd1);
    end
    step(1'b1, 8'h15, 1'b0, "t1.wr5");
    chk("t1.aempty_drop", 32'(aempty), 32'd0);

    // 2: fill with random data, then one overflowing write
    while (mq.size() < DEPTH) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0, "t2.fill");
    chk("t2.full", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b0, "t2.ovf");
    chk("t2.ovf_err", 32'(wr_err), 32'd1);
    chk("t2.ovf_cnt", 32'(count), 32'(DEPTH));
    step(1'b0, 8'h00, 1'b0, "t2.idle");
    chk("t2.err_pulse", 32'(wr_err), 32'd0);

    // 3: drain in order, then one underflowing read
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, "t3.drain");
    step(1'b0, 8'h00, 1'b1, "t3.udf");
    chk("t3.udf_err", 32'(rd_err), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t3.rdata_hold", 32'(rdata), 32'(last_rd));
`endif

    // 4: simultaneous requests at empty and at full
    step(1'b1, 8'hA5, 1'b1, "t4.both_empty");
    chk("t4.cnt1", 32'(count), 32'd1);
    chk("t4.rd_err", 32'(rd_err), 32'd1);
    while (mq.size() < DEPTH) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0, "t4.fill");
    step(1'b1, 8'h5A, 1'b1, "t4.both_full");
    chk("t4.cnt511", 32'(count), 32'(DEPTH - 1));
    chk("t4.wr_err", 32'(wr_err), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t4.oldest", 32'(rdata), 32'h0000_00A5);
`endif
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, "t4.drain");

    // 5: wrap-around traffic, then asynchronous reset between edges
    for (int i = 0; i < 300; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), 1'b0, "t5.wr");
    for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1, "t5.rd");
    for (int i = 0; i < 300; i++) step(1'b1, WIDTH'($urandom_range(0, 255)), (i % 3) == 0, "t5.wrap");
    idle();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t5.async_rst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, "t5.post_rst");
    chk("t5.post_rst_rerr", 32'(rd_err), 32'd1);
    step(1'b1, 8'h77, 1'b0, "t5.post_wr");
    step(1'b0, 8'h00, 1'b1, "t5.post_rd");

`ifdef SYNC_FIFO_FWFT_EN
    // 6: first-word fall-through
    step(1'b1, 8'h3C, 1'b0, "t6.wr");
    chk("t6.head", 32'(rdata), 32'h0000_003C);
    step(1'b0, 8'h00, 1'b1, "t6.pop");
    chk("t6.empty", 32'(empty), 32'd1);
    chk("t6.zero", 32'(rdata), 32'd0);
`endif

    idle();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
